// File: rtl/semafor_port_master.sv
// Bit-memory / semaphore port master: one CPU command at a time,
// waits on WT with a bounded timeout, returns ACK/ERR and a read bit.
module semafor_port_master #(
   parameter int TMO_CYC = 200,
   parameter int ADR_W   = 12
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             REQ,
   input  logic             CMD_WR,
   input  logic [ADR_W-1:0] CMD_ADR,
   input  logic             CMD_DI,
   input  logic             CMD_REL,
   output logic             BUSY,
   output logic             ACK,
   output logic             RDATA,
   output logic             ERR,
   output logic [ADR_W-1:0] A,
   output logic             DI,
   output logic             WE,
   output logic             OE,
   input  logic             WT,
   input  logic             DQ
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      DONE
   } state_t;

   state_t           st;
   state_t           st_nx;
   logic             wr_q;
   logic             di_q;
   logic             abort_q;
   logic             rdata_q;
   logic [ADR_W-1:0] adr_q;
   logic [ADR_W-1:0] adr_nx;
   logic [7:0]       cnt_q;
   logic             tmo;

   assign tmo = (cnt_q == 8'(TMO_CYC - 1));

   // Semaphore reads carry the release flag on address bit 4
   always_comb begin
      adr_nx = CMD_ADR;
      if (!CMD_WR)
         adr_nx[4] = CMD_REL;
   end

   // Next-state: a grant in the limit cycle still wins over timeout
   always_comb begin
      st_nx = st;
      unique case (st)
         IDLE:    if (REQ) st_nx = ISSUE;
         ISSUE: begin
            if (WT)
               st_nx = wr_q ? DONE : CAPTURE;
            else if (tmo)
               st_nx = DONE;
         end
         CAPTURE: st_nx = DONE;
         DONE:    st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   // State, latched command, wait counter, abort flag and read data
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         st      <= IDLE;
         wr_q    <= 1'b0;
         di_q    <= 1'b0;
         abort_q <= 1'b0;
         rdata_q <= 1'b0;
         adr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         st <= st_nx;
         unique case (st)
            IDLE: begin
               if (REQ) begin
                  wr_q    <= CMD_WR;
                  di_q    <= CMD_DI;
                  adr_q   <= adr_nx;
                  cnt_q   <= '0;
                  abort_q <= 1'b0;
               end
            end
            ISSUE: begin
               if (!WT) begin
                  if (tmo)
                     abort_q <= 1'b1;
                  else
                     cnt_q <= cnt_q + 8'd1;
               end
            end
            CAPTURE: rdata_q <= DQ;
            default: ;
         endcase
      end
   end

   assign A     = adr_q;
   assign DI    = di_q;
   assign WE    = (st == ISSUE) &&  wr_q;
   assign OE    = (st == ISSUE) && !wr_q;
   assign BUSY  = (st != IDLE);
   assign ACK   = (st == DONE);
   assign ERR   = (st == DONE) && abort_q;
   assign RDATA = rdata_q;

endmodule

// File: tb/tb_semafor_port_master.sv
// Scoreboard bench for semafor_port_master: two instances, the
// second with a short timeout for abort and grant-boundary cases.
module tb_semafor_port_master;

   logic        CLK = 1'b0;
   logic        CLR = 1'b0;
   logic        req = 1'b0;
   logic        req4 = 1'b0;
   logic        cmd_wr = 1'b0;
   logic [11:0] cmd_adr = '0;
   logic        cmd_di = 1'b0;
   logic        cmd_rel = 1'b0;
   logic        wt = 1'b0;
   logic        wt4 = 1'b0;
   logic        dq = 1'b0;
   logic        dq4 = 1'b0;

   logic        busy, ack, rdata, err, di, we, oe;
   logic [11:0] a;
   logic        busy4, ack4, rdata4, err4, di4, we4, oe4;
   logic [11:0] a4;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   bit mem [4096];

   typedef struct {
      int   c0;
      int   lat;
      logic err;
      logic chk;
      logic rd;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   semafor_port_master u_dut (
      .CLK(CLK), .CLR(CLR), .REQ(req), .CMD_WR(cmd_wr),
      .CMD_ADR(cmd_adr), .CMD_DI(cmd_di), .CMD_REL(cmd_rel),
      .BUSY(busy), .ACK(ack), .RDATA(rdata), .ERR(err),
      .A(a), .DI(di), .WE(we), .OE(oe), .WT(wt), .DQ(dq)
   );

   semafor_port_master #(.TMO_CYC(4)) u_tmo (
      .CLK(CLK), .CLR(CLR), .REQ(req4), .CMD_WR(cmd_wr),
      .CMD_ADR(cmd_adr), .CMD_DI(cmd_di), .CMD_REL(cmd_rel),
      .BUSY(busy4), .ACK(ack4), .RDATA(rdata4), .ERR(err4),
      .A(a4), .DI(di4), .WE(we4), .OE(oe4), .WT(wt4), .DQ(dq4)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Memory model: read data one cycle after the address
   always @(posedge CLK) begin
      dq  <= mem[a];
      dq4 <= mem[a4];
      if (we && wt)   mem[a]  <= di;
      if (we4 && wt4) mem[a4] <= di4;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_ack(input string nm, input exp_t e,
                          input logic er, input logic rd);
      chk({nm, " latency"}, cyc - e.c0, e.lat);
      chk({nm, " err"}, er, e.err);
      if (e.chk) chk({nm, " rdata"}, rd, e.rd);
   endtask

   // Monitor: pop expectations on every ACK, guard strobe exclusivity
   always @(negedge CLK) begin
      if (CLR) begin
         if (we && oe)   chk("we_oe_excl", 1, 0);
         if (we4 && oe4) chk("we_oe_excl4", 1, 0);
         if (ack) begin
            if (q0.size() == 0) chk("ack unexpected", 1, 0);
            else chk_ack("ack", q0.pop_front(), err, rdata);
         end
         if (ack4) begin
            if (q1.size() == 0) chk("ack4 unexpected", 1, 0);
            else chk_ack("ack4", q1.pop_front(), err4, rdata4);
         end
      end
   end

   // Issue one command; called just after a falling edge
   task automatic run(input int sel, input logic wr,
                      input logic [11:0] adr, input logic d,
                      input logic rel, input int nwait,
                      input logic hold, input logic [11:0] ea,
                      input int elat, input int estrb,
                      input logic eerr, input logic ck,
                      input logic erd);
      int   k = 0;
      int   strb = 0;
      logic bad_a = 1'b0;
      logic done = 1'b0;
      exp_t e;
      cmd_wr  = wr;
      cmd_adr = adr;
      cmd_di  = d;
      cmd_rel = rel;
      e = '{c0: cyc, lat: elat, err: eerr, chk: ck, rd: erd};
      if (sel == 0) begin
         req = 1'b1;
         wt  = 1'b0;
         q0.push_back(e);
      end else begin
         req4 = 1'b1;
         wt4  = 1'b0;
         q1.push_back(e);
      end
      while (!done && k < 40) begin
         @(negedge CLK);
         k++;
         if (sel == 0) begin
            if (!hold) req = 1'b0;
            wt = (k > nwait);
            if (!busy) begin
               done = 1'b1;
               req  = 1'b0;
            end else if (we || oe) begin
               strb++;
               if (a !== ea) bad_a = 1'b1;
            end
         end else begin
            if (!hold) req4 = 1'b0;
            wt4 = (k > nwait);
            if (!busy4) begin
               done = 1'b1;
               req4 = 1'b0;
            end else if (we4 || oe4) begin
               strb++;
               if (a4 !== ea) bad_a = 1'b1;
            end
         end
      end
      chk("run completes", done, 1);
      chk("strobe cycles", strb, estrb);
      chk("address stable", bad_a, 0);
   endtask

   initial begin
      mem[12'h000] = 1'b1;
      mem[12'h818] = 1'b1;
      #3;
      chk("rst busy", busy, 0);
      chk("rst ack", ack, 0);
      chk("rst err", err, 0);
      chk("rst we", we, 0);
      chk("rst oe", oe, 0);
      chk("rst rdata", rdata, 0);
      chk("rst a", a, 0);
      chk("rst di", di, 0);
      repeat (2) @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);

      // Plain write, plain read, semaphore read with waits
      run(0, 1, 12'h005, 1, 0, 0, 0, 12'h005, 2, 1, 0, 0, 0);
      run(0, 0, 12'h000, 0, 0, 0, 0, 12'h000, 3, 1, 0, 1, 1);
      run(0, 0, 12'h808, 0, 1, 5, 0, 12'h818, 8, 6, 0, 1, 1);
      run(0, 0, 12'h005, 0, 0, 1, 0, 12'h005, 4, 2, 0, 1, 1);
      run(0, 0, 12'h010, 0, 0, 0, 0, 12'h000, 3, 1, 0, 1, 1);
      run(0, 1, 12'h011, 0, 1, 0, 0, 12'h011, 2, 1, 0, 0, 0);
      chk("mem 011 written", mem[12'h011], 0);

      // REQ held through a busy write, then REQ right after ACK
      run(0, 1, 12'h020, 1, 0, 2, 1, 12'h020, 4, 3, 0, 0, 0);
      run(0, 0, 12'h020, 0, 0, 0, 0, 12'h020, 3, 1, 0, 1, 1);

      // Asynchronous reset during ISSUE drops the transaction
      cmd_wr  = 1'b1;
      cmd_adr = 12'h030;
      cmd_di  = 1'b1;
      req     = 1'b1;
      wt      = 1'b0;
      @(negedge CLK);
      req = 1'b0;
      chk("pre-clr we", we, 1);
      #2 CLR = 1'b0;
      #1;
      chk("clr we", we, 0);
      chk("clr oe", oe, 0);
      chk("clr busy", busy, 0);
      chk("clr rdata", rdata, 0);
      @(negedge CLK);
      CLR = 1'b1;
      repeat (3) @(negedge CLK);
      chk("mem 030 untouched", mem[12'h030], 0);
      run(0, 1, 12'h031, 1, 0, 0, 0, 12'h031, 2, 1, 0, 0, 0);

      // Short-timeout instance: grant at the limit, aborts
      run(1, 0, 12'h000, 0, 0, 0, 0, 12'h000, 3, 1, 0, 1, 1);
      run(1, 1, 12'h800, 1, 0, 3, 0, 12'h800, 5, 4, 0, 0, 0);
      chk("mem 800 written", mem[12'h800], 1);
      run(1, 1, 12'h801, 1, 0, 99, 0, 12'h801, 5, 4, 1, 0, 0);
      chk("mem 801 untouched", mem[12'h801], 0);
      chk("busy4 after abort", busy4, 0);
      run(1, 0, 12'h802, 0, 0, 99, 0, 12'h802, 5, 4, 1, 1, 1);

      repeat (4) @(negedge CLK);
      chk("queue0 drained", q0.size(), 0);
      chk("queue1 drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
